// File: rtl/gray_step_ctrl.sv
// gray_step_ctrl: steps a binary-held Gray code N steps up/down with pause; define GRAY_LOAD_EN for load/load_val preset ports
module gray_step_ctrl #(
  parameter int N  = 4,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir,
  input  logic [SW-1:0] steps,
  input  logic          pause,
  input  logic          clr,
`ifdef GRAY_LOAD_EN
  input  logic          load,
  input  logic [N-1:0]  load_val,
`endif
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] remaining,
  output logic [N-1:0]  gray_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t nxt, state;
  logic [N-1:0] bin, bin_n, ld_bin;
  logic [SW-1:0] rem_n;
  logic dir_q, dir_n, ld, step, go;
  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) g2b[i] = ^(g >> i);
  endfunction
`ifdef GRAY_LOAD_EN
  assign ld = load;
  assign ld_bin = g2b(load_val);
`else
  assign ld = 1'b0;
  assign ld_bin = '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      bin <= '0;
      dir_q <= 1'b0;
      remaining <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      gray_out <= '0;
    end else begin
      state <= nxt;
      bin <= bin_n;
      dir_q <= dir_n;
      remaining <= rem_n;
      busy <= nxt == RUN;
      done <= nxt == DONE;
      gray_out <= bin_n ^ (bin_n >> 1);
    end
  end
  always_comb begin
    nxt = state == IDLE ? ((clr || ld || !start) ? IDLE : (steps == '0 ? DONE : RUN))
        : state == RUN ? ((!pause && remaining == SW'(1)) ? DONE : RUN)
        : IDLE;
  end
  // clr outranks load, both outrank start; only IDLE reacts to them
  always_comb begin
    step = state == RUN && !pause;
    go = state == IDLE && start && !clr && !ld;
    bin_n = (state == IDLE && clr) ? '0
          : (state == IDLE && ld) ? ld_bin
          : step ? (dir_q ? bin + N'(1) : bin - N'(1))
          : bin;
    rem_n = go ? steps : step ? remaining - SW'(1) : remaining;
    dir_n = go ? dir : dir_q;
  end
endmodule
